// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int n_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Elaboration-time legality of a WIDTH/CHUNK pair.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit ripple slice: adds chunk IDX and shifts its sum into the top of the travelling sum.
// One register stage; every register holds while en is low.
module adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_carry,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum
);

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] chunk_sum;
    logic [CHUNK:0]   c;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        ca = in_a[IDX*CHUNK +: CHUNK];
        cb = in_b[IDX*CHUNK +: CHUNK];
        chunk_sum = '0;
        c = '0;
        c[0] = in_carry;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = ca[i] ^ cb[i] ^ c[i];
            c[i+1]       = (ca[i] & cb[i]) | (c[i] & (ca[i] ^ cb[i]));
        end
        // Lower chunks drift down one slot per stage, so the sum lands aligned after the last stage.
        sum_nxt = in_sum >> CHUNK;
        sum_nxt[WIDTH-CHUNK +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_carry <= c[CHUNK];
            out_a     <= in_a;
            out_b     <= in_b;
            out_sum   <= sum_nxt;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub with a registered carry every CHUNK bits; one beat per cycle.
// Latency STAGES cycles; a stalled result freezes every stage and drops IN_READY combinationally.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             Z
);

    localparam int STAGES = n_stages(WIDTH, CHUNK);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic                         en;
    logic                         in_fire;
    logic [WIDTH-1:0]             b_eff;
    logic                         c0;
    logic [STAGES:1]              vld;
    logic [STAGES:1]              carry;
    logic [STAGES:1][WIDTH-1:0]   a_p;
    logic [STAGES:1][WIDTH-1:0]   b_p;
    logic [STAGES:1][WIDTH-1:0]   sum_p;

    assign en       = !(OUT_VALID && !OUT_READY);
    assign IN_READY = en;
    assign in_fire  = IN_VALID && en;
    assign b_eff    = (SUB == OP_ADD) ? B : ~B;
    assign c0       = (SUB == OP_SUB) ? ~CI : CI;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             st_vld;
        logic             st_carry;
        logic [WIDTH-1:0] st_a;
        logic [WIDTH-1:0] st_b;
        logic [WIDTH-1:0] st_sum;

        if (k == 0) begin : g_head
            assign st_vld   = in_fire;
            assign st_carry = c0;
            assign st_a     = A;
            assign st_b     = b_eff;
            assign st_sum   = '0;
        end else begin : g_tail
            assign st_vld   = vld[k];
            assign st_carry = carry[k];
            assign st_a     = a_p[k];
            assign st_b     = b_p[k];
            assign st_sum   = sum_p[k];
        end

        adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
            .clk      (CLK),
            .rst      (RST),
            .en       (en),
            .in_valid (st_vld),
            .in_carry (st_carry),
            .in_a     (st_a),
            .in_b     (st_b),
            .in_sum   (st_sum),
            .out_valid(vld[k+1]),
            .out_carry(carry[k+1]),
            .out_a    (a_p[k+1]),
            .out_b    (b_p[k+1]),
            .out_sum  (sum_p[k+1])
        );
    end

    // Flags derive only from last-stage registers, so they hold with S during a stall.
    assign OUT_VALID = vld[STAGES];
    assign S         = sum_p[STAGES];
    assign CO        = carry[STAGES];
    assign OV        = (a_p[STAGES][WIDTH-1] == b_p[STAGES][WIDTH-1]) &&
                       (S[WIDTH-1] != a_p[STAGES][WIDTH-1]);
    assign Z         = OUT_VALID && (S == '0);

    logic unused_passthru;
    assign unused_passthru = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder against an arithmetic reference model.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ci = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             co, ov, z;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [18:0] exp_q[$];
    logic [18:0] got_q[$];
    int          pop_cyc[$];
    logic        last_acc = 1'b0;
    logic        last_pop = 1'b0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .CI(ci), .SUB(sub),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .S(s), .CO(co), .OV(ov), .Z(z)
    );

    // Result = {S, CO, OV, Z} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msub);
        int ua, ub, sa, sb, r, sr;
        logic [15:0] rs;
        logic rco, rov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub == OP_ADD) begin
            r = ua + ub + int'(mci);
            rco = (r > 65535);
            sr = sa + sb + int'(mci);
        end else begin
            r = ua - ub - int'(mci);
            rco = (r >= 0);
            sr = sa - sb - int'(mci);
        end
        rs = r[15:0];
        rov = (sr > 32767) || (sr < -32768);
        return {rs, rco, rov, rs == 16'd0};
    endfunction

    // Records handshakes just before the edge, then returns at the following falling edge.
    task automatic tick();
        #1;
        last_acc = (in_valid && in_ready) === 1'b1;
        last_pop = (out_valid && out_ready) === 1'b1;
        if (last_acc) exp_q.push_back(model(a, b, ci, sub));
        if (last_pop) begin
            got_q.push_back({s, co, ov, z});
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        pop_cyc.delete();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== 16'h0000)     begin errors++; $display("FAIL reset_s got=%h exp=0000", s); end
        checks++; if (co !== 1'b0)        begin errors++; $display("FAIL reset_co got=%b exp=0", co); end
        checks++; if (ov !== 1'b0)        begin errors++; $display("FAIL reset_ov got=%b exp=0", ov); end
        checks++; if (z !== 1'b0)         begin errors++; $display("FAIL reset_z got=%b exp=0", z); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        clear_q();
    endtask

    task automatic test_directed();
        logic [15:0] va[5]   = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0000, 16'h8000};
        logic [15:0] vb[5]   = '{16'h0001, 16'h0001, 16'h0007, 16'h0000, 16'h0001};
        logic        vci[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vsub[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
        logic [18:0] vexp[5] = '{{16'h0000, 3'b101}, {16'h8000, 3'b010}, {16'hFFFE, 3'b000},
                                 {16'hFFFF, 3'b000}, {16'h7FFF, 3'b110}};
        int n;
        clear_q();
        out_ready = 1'b1;
        a = va[0]; b = vb[0]; ci = vci[0]; sub = vsub[0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != STAGES) begin errors++; $display("FAIL dir_latency got=%0d exp=%0d", n, STAGES); end
        for (int k = 1; k < 5; k++) begin
            a = va[k]; b = vb[k]; ci = vci[k]; sub = vsub[k];
            in_valid = 1'b1;
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL dir_count got=%0d exp=5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== vexp[k]) begin
                errors++;
                $display("FAIL dir_beat%0d got S/CO/OV/Z=%h/%b exp=%h/%b", k, got_q[k][18:3], got_q[k][2:0], vexp[k][18:3], vexp[k][2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 16'(i); b = 16'(i * 16'h1000); ci = 1'b0; sub = OP_ADD;
            in_valid = 1'b1;
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL b2b_count got=%0d exp=8 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
            checks++;
            if (pop_cyc[k] != pop_cyc[0] + k) begin
                errors++; $display("FAIL b2b_gap%0d got_cycle=%0d exp_cycle=%0d", k, pop_cyc[k], pop_cyc[0] + k);
            end
        end
    endtask

    task automatic test_backpressure();
        int i = 0;
        logic [15:0] held = '0;
        clear_q();
        for (int j = 0; j < 30; j++) begin
            out_ready = !(j >= 5 && j <= 7);
            in_valid = (i < 8);
            a = 16'(i); b = 16'(i * 16'h1000); ci = 1'b0; sub = OP_ADD;
            #1;
            if (j >= 5 && j <= 7) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got=%b exp=1", j, out_valid); end
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d got=%b exp=0", j, in_ready); end
                if (j == 5) held = s;
                else begin
                    checks++;
                    if (s !== held) begin errors++; $display("FAIL bp_hold_c%0d got=%h exp=%h", j, s, held); end
                end
            end
            tick();
            if (last_acc) i++;
        end
        in_valid = 1'b0;
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL bp_count got=%0d exp=8 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_flush();
        int n;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        exp_q.delete();
        repeat (STAGES + 2) tick();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL flush_leak got=%0d beats exp=0", got_q.size()); end
        a = 16'h1234; b = 16'h4321; ci = 1'b1; sub = OP_SUB;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != STAGES) begin errors++; $display("FAIL flush_latency got=%0d exp=%0d", n, STAGES); end
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL flush_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_beat got=%h exp=%h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_random();
        clear_q();
        in_valid = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid === 1'b1 && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_stall_ready_c%0d got=%b exp=0", j, in_ready); end
            end
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd_beat%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit: the successor of the 4-bit ripple-carry adder, generalised to WIDTH bits. The carry chain is split into CHUNK-bit segments with a registered carry between segments. Operands enter through a valid/ready handshake and results leave through one, at one result per cycle. It sits in the datapath wherever a WIDTH-bit add/sub is too long to ripple in one cycle.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1)
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  reset; synchronous and active-high
- IN_VALID  in  1  operand beat present
- IN_READY  out  1  unit can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CI  in  1  carry-in (ADD) / borrow-in (SUB)
- SUB  in  1  0: S = A + B + CI; 1: S = A − B − CI
- OUT_VALID  out  1  result beat present
- OUT_READY  in  1  downstream accepts result
- S  out  WIDTH  result
- CO  out  1  carry out of MSB (SUB: 1 = no borrow)
- OV  out  1  two's-complement signed overflow
- Z  out  1  S == 0

## Operation
- Effective operands: b_eff = SUB ? ~B : B; c0 = SUB ? ~CI : CI. Every stage adds A chunk + b_eff chunk + incoming carry.
- Stage k (k = 0..STAGES−1) adds bits [k·CHUNK +: CHUNK] with the carry registered from stage k−1; stage 0 uses c0.
- Unprocessed upper chunks of A and b_eff, and already-computed lower sum chunks, travel with the beat (skew/deskew registers). The result emerges aligned.
- Each stage has its own valid bit. Empty stages (bubbles) advance like full ones.
- Global advance enable: en = !(OUT_VALID && !OUT_READY). IN_READY = en. The combinational path OUT_READY→IN_READY is intentional.
- When en = 1, every stage shifts one position. A beat is accepted when IN_VALID && IN_READY. When en = 0, all pipeline registers hold.
- Last stage computes flags:
  - CO = final carry.
  - OV = (A[MSB] == b_eff[MSB]) && (S[MSB] != A[MSB]).
  - Z = (S == 0).
- S, CO, OV and Z are registered together with OUT_VALID, and are stable while OUT_VALID && !OUT_READY.

## Timing
- Latency: a beat accepted at rising edge t shows OUT_VALID = 1 with its result after edge t+STAGES−1, i.e. STAGES register stages.
- Throughput: 1 beat/cycle while OUT_READY = 1.
- Reset: all stage valids, OUT_VALID, S, CO, OV and Z are 0 after the first RST edge. IN_READY = 1 while RST is low and the pipeline is empty.
- RST asserted mid-operation drops all in-flight beats; no partial result is ever presented.
- Simultaneous output pop and input push on a full pipeline is allowed, with no bubble inserted.
- Backpressure: while OUT_READY = 0 and OUT_VALID = 1, IN_READY = 0 and no beat is lost or duplicated. Release resumes the next cycle.
- IN_VALID with IN_READY = 0 is ignored. The source must hold A, B, CI and SUB until accepted.
- STAGES = 1 degenerates to a registered single-cycle adder with identical handshake semantics.

## Structure
- Package pipe_adder_pkg holds:
  - function n_stages(WIDTH, CHUNK)
  - an elaboration check that WIDTH % CHUNK == 0
  - localparams for the SUB encoding (OP_ADD = 0, OP_SUB = 1)
- Sub-module adder_stage: one CHUNK-bit full-adder ripple plus its valid, carry and pass-through registers, with an enable input. It is instantiated STAGES times via generate. The top level holds the en logic and the flag computation.

## Test plan
(WIDTH=16, CHUNK=4, STAGES=4)
- Reset then idle → OUT_VALID=0, S=0, CO=0, OV=0, Z=0, IN_READY=1.
- ADD A=0xFFFF, B=0x0001, CI=0 → after 4 edges S=0x0000, CO=1, Z=1, OV=0. This checks carry propagation across all chunk boundaries.
- ADD A=0x7FFF, B=0x0001, CI=0 → S=0x8000, CO=0, OV=1. SUB A=0x0005, B=0x0007, CI=0 → S=0xFFFE, CO=0 (borrow), OV=0.
- 8 back-to-back beats (A=i, B=0x1000·i) with OUT_READY=1 → 8 consecutive OUT_VALID cycles, in order, correct sums.
- Same stream with OUT_READY low for cycles 5–7 → IN_READY low on those cycles, S held stable, all 8 results delivered exactly once, in order.
- RST pulsed with 3 beats in flight → OUT_VALID=0 the next cycle, those beats never appear. A beat pushed after reset emerges 4 cycles later, correct.
